taxi_stats_accum: RTL and testbench
===================================

Name: taxi_stats_accum

Overview:
- Consumer end of the MAC statistics stream. Each beat carries a counter ID and an increment. The block accumulates these into wide per-ID counters held in on-chip RAM.
- Provides a request/response read port with optional clear-on-read for host/CSR logic.
- Sits on the stat clock domain, downstream of each MAC instance's stat output.

Parameters:
- ID_W, 8, counter index width; number of counters N = 2**ID_W
- INC_W, 16, increment width (stat stream data width)
- CNT_W, 64, counter width; CNT_W > INC_W

Ports:
- clk  in  1  stat clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_stat_tdata  in  INC_W  increment value
- s_axis_stat_tid  in  ID_W  counter index
- s_axis_stat_tuser  in  1  0 = add tdata to counter; 1 = load tdata, zero-extended
- s_axis_stat_tvalid  in  1  beat valid
- s_axis_stat_tready  out  1  beat accepted when tvalid & tready
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  request accepted when valid & ready
- rd_req_id  in  ID_W  counter to read
- rd_req_clear  in  1  1 = zero the counter after reading
- rd_resp_valid  out  1  one-cycle pulse, response data valid
- rd_resp_data  out  CNT_W  counter value
- init_done  out  1  high once the post-reset clear sweep is complete

Behaviour:
- Reset values: s_axis_stat_tready=0, rd_req_ready=0, rd_resp_valid=0, rd_resp_data=0, init_done=0. Pipeline valids are cleared and the init pointer is set to 0.
- INIT state:
  - Writes 0 to address ptr each cycle, ptr = 0..N-1 (N cycles).
  - Then init_done=1 and the state moves to RUN.
  - Both ready outputs are held 0 throughout INIT.
- RUN state:
  - One operation enters the pipeline per cycle.
  - The two ready outputs are never both 1 in the same cycle.
  - When only one requester is valid, it is granted.
  - When both are valid, grant alternates (round-robin toggle, stat wins the first conflict after init). Neither source can starve.
- Pipeline stages:
  - S0: accept and issue RAM read address.
  - S1: RAM read data returns (1-cycle registered RAM).
  - S2: compute new value, write RAM, drive response.
- Stat update: new = tuser ? zero-extend(tdata) : old + zero-extend(tdata), modulo 2**CNT_W (wrap).
- Read request:
  - rd_resp_data = old value, with rd_resp_valid pulsing in the S2 cycle. Latency is exactly 2 cycles after the accept cycle.
  - If rd_req_clear=1, writes 0; otherwise no write.
- Hazards:
  - When an op in S1 or S2 targets the same ID as the op behind it, the later op uses the forwarded S2 result, not the stale RAM data.
  - Back-to-back same-ID adds must accumulate exactly.
- A read followed by a same-ID add with clear=1: the read returns the pre-clear value; the add starts from 0.
- Asserting rst_n low mid-operation abandons in-flight ops, drops rd_resp_valid, and restarts INIT.

Optional Feature:
- Macro: TAXI_STATS_ACCUM_SATURATE_EN.
- Defined: adds clamp at 2**CNT_W-1 instead of wrapping, and a counter at max stays at max. Loads (tuser=1) and clears are unaffected.
- Undefined: modulo wrap as in Behaviour.

Decomposition:
- Shared package taxi_stats_pkg holds:
  - typedef enum state_t {INIT, RUN}
  - typedef struct op_t {valid, is_rd, clear, load, id, inc}
  - localparam defaults for ID_W, INC_W, CNT_W
- One natural sub-module, taxi_stats_accum_ram: simple dual-port, 1-cycle registered read, write-first not required (forwarding handles hazards).

Test Plan:
- Reset release -> init_done rises exactly N=256 cycles later; readback of all 256 IDs returns 0.
- Stat beats id=5 data=3, then id=5 data=7 on consecutive cycles -> read id=5 returns 10 (forwarding check).
- Stat id=9 data=0xFFFF repeated 4 times, then read id=9 with clear=1 -> returns 0x3FFFC; a second read returns 0.
- Preload id=2 to 2**64-2 via load/add beats, then add 5 -> read returns 3 (wrap), or 2**64-1 with TAXI_STATS_ACCUM_SATURATE_EN.
- Stat tvalid and rd_req_valid held high together for 20 cycles -> grants strictly alternate; every read response arrives 2 cycles after its accept.
- rst_n pulsed low while 2 ops are in flight -> no rd_resp_valid after reset; INIT reruns; all counters read 0.

Source files
------------

// File: rtl/taxi_stats_pkg.sv
// Shared types and default widths for the statistics accumulator.
// op_t is sized from the STATS_* defaults, so ID_W and INC_W of the top must
// stay at these values. CNT_W may be changed freely.
package taxi_stats_pkg;

  localparam int STATS_ID_W  = 8;
  localparam int STATS_INC_W = 16;
  localparam int STATS_CNT_W = 64;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_rd;
    logic                   clear;
    logic                   load;
    logic [STATS_ID_W-1:0]  id;
    logic [STATS_INC_W-1:0] inc;
  } op_t;

endpackage

// File: rtl/taxi_stats_accum_ram.sv
// Counter storage: simple dual-port RAM with a registered read port.
// A read of an address written on the same edge returns the old contents;
// the accumulator pipeline forwards around that.
module taxi_stats_accum_ram
  import taxi_stats_pkg::*;
#(
  parameter int ADDR_W = STATS_ID_W,
  parameter int DATA_W = STATS_CNT_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // Write port and one-cycle registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/taxi_stats_accum.sv
// Statistics accumulator: per-ID wide counters updated from a stat stream,
// with a request/response read port supporting clear-on-read.
// Optional build macro TAXI_STATS_ACCUM_SATURATE_EN makes adds clamp at the
// counter maximum instead of wrapping.
// Pipeline: S0 arbitrate and issue RAM read, S1 RAM data returns and the new
// value is computed, S2 writes the RAM and presents the read response.
module taxi_stats_accum
  import taxi_stats_pkg::*;
#(
  parameter int ID_W  = STATS_ID_W,
  parameter int INC_W = STATS_INC_W,
  parameter int CNT_W = STATS_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INC_W-1:0] s_axis_stat_tdata,
  input  logic [ID_W-1:0]  s_axis_stat_tid,
  input  logic             s_axis_stat_tuser,
  input  logic             s_axis_stat_tvalid,
  output logic             s_axis_stat_tready,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [ID_W-1:0]  rd_req_id,
  input  logic             rd_req_clear,
  output logic             rd_resp_valid,
  output logic [CNT_W-1:0] rd_resp_data,
  output logic             init_done
);

  localparam logic [ID_W-1:0] LAST_ID = '1;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             init_done_q, init_done_d;
  logic             rr_rd_q, rr_rd_d;

  logic             stat_grant, rd_grant;
  op_t              s0_op, s1_q, s1_d;
  logic [CNT_W-1:0] s1_old, s1_new, inc_ext;

  logic             s2_valid_q, s2_valid_d;
  logic             s2_we_q, s2_we_d;
  logic [ID_W-1:0]  s2_id_q, s2_id_d;
  logic [CNT_W-1:0] s2_new_q, s2_new_d;

  logic             s3_valid_q, s3_valid_d;
  logic [ID_W-1:0]  s3_id_q, s3_id_d;
  logic [CNT_W-1:0] s3_new_q, s3_new_d;

  logic             resp_valid_q, resp_valid_d;
  logic [CNT_W-1:0] resp_data_q, resp_data_d;

  logic             ram_we;
  logic [ID_W-1:0]  ram_waddr;
  logic [CNT_W-1:0] ram_wdata, ram_rdata;

`ifdef TAXI_STATS_ACCUM_SATURATE_EN
  logic [CNT_W:0]   sum;
`endif

  // Init sweep sequencing: walk every address once, then enter RUN.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_done_d = init_done_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + ID_W'(1);
      if (ptr_q == LAST_ID) begin
        state_d     = RUN;
        init_done_d = 1'b1;
        ptr_d       = '0;
      end
    end
  end

  // Arbitrate one op per cycle; on a conflict the toggle alternates winners.
  always_comb begin
    stat_grant = 1'b0;
    rd_grant   = 1'b0;
    rr_rd_d    = rr_rd_q;
    if (state_q == RUN) begin
      if (s_axis_stat_tvalid && rd_req_valid) begin
        rd_grant   = rr_rd_q;
        stat_grant = !rr_rd_q;
        rr_rd_d    = !rr_rd_q;
      end else begin
        stat_grant = s_axis_stat_tvalid;
        rd_grant   = rd_req_valid;
      end
    end
  end

  // Package the granted request as the S0 op.
  always_comb begin
    s0_op       = '0;
    s0_op.valid = stat_grant | rd_grant;
    s0_op.is_rd = rd_grant;
    s0_op.clear = rd_grant & rd_req_clear;
    s0_op.load  = stat_grant & s_axis_stat_tuser;
    s0_op.id    = rd_grant ? rd_req_id : s_axis_stat_tid;
    s0_op.inc   = stat_grant ? s_axis_stat_tdata : '0;
  end

  // S1: pick the freshest old value and compute the value after this op.
  always_comb begin
    s1_old = ram_rdata;
    if (s3_valid_q && (s3_id_q == s1_q.id)) begin
      s1_old = s3_new_q;
    end
    if (s2_valid_q && (s2_id_q == s1_q.id)) begin
      s1_old = s2_new_q;
    end
    inc_ext = CNT_W'(s1_q.inc);
    if (s1_q.is_rd) begin
      s1_new = s1_q.clear ? '0 : s1_old;
    end else if (s1_q.load) begin
      s1_new = inc_ext;
    end else begin
`ifdef TAXI_STATS_ACCUM_SATURATE_EN
      sum    = {1'b0, s1_old} + {1'b0, inc_ext};
      s1_new = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
      s1_new = s1_old + inc_ext;
`endif
    end
  end

  // Advance the pipeline and form the read response.
  always_comb begin
    s1_d         = s0_op;
    s2_valid_d   = s1_q.valid;
    s2_we_d      = s1_q.valid && (!s1_q.is_rd || s1_q.clear);
    s2_id_d      = s1_q.id;
    s2_new_d     = s1_new;
    s3_valid_d   = s2_valid_q;
    s3_id_d      = s2_id_q;
    s3_new_d     = s2_new_q;
    resp_valid_d = s1_q.valid && s1_q.is_rd;
    resp_data_d  = resp_valid_d ? s1_old : resp_data_q;
  end

  // RAM write port: zero sweep during INIT, S2 results during RUN.
  always_comb begin
    if (state_q == INIT) begin
      ram_we    = 1'b1;
      ram_waddr = ptr_q;
      ram_wdata = '0;
    end else begin
      ram_we    = s2_we_q;
      ram_waddr = s2_id_q;
      ram_wdata = s2_new_q;
    end
  end

  // All control and pipeline state; reset abandons in-flight ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      ptr_q        <= '0;
      init_done_q  <= 1'b0;
      rr_rd_q      <= 1'b0;
      s1_q         <= '0;
      s2_valid_q   <= 1'b0;
      s2_we_q      <= 1'b0;
      s2_id_q      <= '0;
      s2_new_q     <= '0;
      s3_valid_q   <= 1'b0;
      s3_id_q      <= '0;
      s3_new_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      init_done_q  <= init_done_d;
      rr_rd_q      <= rr_rd_d;
      s1_q         <= s1_d;
      s2_valid_q   <= s2_valid_d;
      s2_we_q      <= s2_we_d;
      s2_id_q      <= s2_id_d;
      s2_new_q     <= s2_new_d;
      s3_valid_q   <= s3_valid_d;
      s3_id_q      <= s3_id_d;
      s3_new_q     <= s3_new_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  taxi_stats_accum_ram #(
    .ADDR_W (ID_W),
    .DATA_W (CNT_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (s0_op.id),
    .rd_data (ram_rdata)
  );

  assign s_axis_stat_tready = stat_grant;
  assign rd_req_ready       = rd_grant;
  assign rd_resp_valid      = resp_valid_q;
  assign rd_resp_data       = resp_data_q;
  assign init_done          = init_done_q;

endmodule

// File: tb/tb_taxi_stats_accum.sv
// Testbench for taxi_stats_accum. The counter width is narrowed to 20 bits so
// the wrap/clamp boundary is reachable with 16-bit increments in a few beats.
// Reference model: one plain array of counter values updated in accept order,
// plus a queue of expected read responses stamped with their due cycle.
module tb_taxi_stats_accum;

  localparam int TB_ID_W  = 8;
  localparam int TB_INC_W = 16;
  localparam int TB_CNT_W = 20;
  localparam int N        = 256;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [TB_INC_W-1:0] s_axis_stat_tdata = '0;
  logic [TB_ID_W-1:0]  s_axis_stat_tid = '0;
  logic                s_axis_stat_tuser = 1'b0;
  logic                s_axis_stat_tvalid = 1'b0;
  logic                s_axis_stat_tready;
  logic                rd_req_valid = 1'b0;
  logic                rd_req_ready;
  logic [TB_ID_W-1:0]  rd_req_id = '0;
  logic                rd_req_clear = 1'b0;
  logic                rd_resp_valid;
  logic [TB_CNT_W-1:0] rd_resp_data;
  logic                init_done;

  always #5 clk = ~clk;

  taxi_stats_accum #(
    .ID_W  (TB_ID_W),
    .INC_W (TB_INC_W),
    .CNT_W (TB_CNT_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_axis_stat_tdata  (s_axis_stat_tdata),
    .s_axis_stat_tid    (s_axis_stat_tid),
    .s_axis_stat_tuser  (s_axis_stat_tuser),
    .s_axis_stat_tvalid (s_axis_stat_tvalid),
    .s_axis_stat_tready (s_axis_stat_tready),
    .rd_req_valid       (rd_req_valid),
    .rd_req_ready       (rd_req_ready),
    .rd_req_id          (rd_req_id),
    .rd_req_clear       (rd_req_clear),
    .rd_resp_valid      (rd_resp_valid),
    .rd_resp_data       (rd_resp_data),
    .init_done          (init_done)
  );

  typedef struct {
    int                  due;
    logic [TB_ID_W-1:0]  id;
    logic [TB_CNT_W-1:0] data;
  } resp_t;

  int                  tests_run = 0;
  int                  tests_failed = 0;
  int                  cyc = 0;
  logic [TB_CNT_W-1:0] model_cnt [N];
  resp_t               exp_q [$];
  bit                  next_conflict_stat = 1'b1;
  bit                  last_stat_acc = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counter arithmetic straight from the rules: add wraps (or clamps).
  function automatic logic [TB_CNT_W-1:0] modelAdd(input logic [TB_CNT_W-1:0] old,
                                                   input logic [TB_INC_W-1:0] inc);
    logic [TB_CNT_W:0] total;
    total = {1'b0, old} + {{(TB_CNT_W + 1 - TB_INC_W){1'b0}}, inc};
`ifdef TAXI_STATS_ACCUM_SATURATE_EN
    if (total[TB_CNT_W]) return '1;
`endif
    return total[TB_CNT_W-1:0];
  endfunction

  task automatic checkResp();
    bit exp_v;
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    checkOutput("resp_valid", 64'(rd_resp_valid), 64'(exp_v));
    if (exp_v) begin
      checkOutput($sformatf("resp_data id%0d", exp_q[0].id), 64'(rd_resp_data), 64'(exp_q[0].data));
      void'(exp_q.pop_front());
    end
  endtask

  // One clock of stimulus; called just after a falling edge.
  task automatic applyStimulus(input bit sv, input logic [TB_ID_W-1:0] sid,
                               input logic [TB_INC_W-1:0] sdat, input bit su,
                               input bit rv, input logic [TB_ID_W-1:0] rid, input bit rc);
    bit    sa, ra, exp_sa, exp_ra;
    resp_t e;
    s_axis_stat_tvalid = sv;
    s_axis_stat_tid    = sid;
    s_axis_stat_tdata  = sdat;
    s_axis_stat_tuser  = su;
    rd_req_valid       = rv;
    rd_req_id          = rid;
    rd_req_clear       = rc;
    #1;
    sa = sv & s_axis_stat_tready;
    ra = rv & rd_req_ready;
    exp_sa = sv;
    exp_ra = rv;
    if (sv && rv) begin
      exp_sa = next_conflict_stat;
      exp_ra = !next_conflict_stat;
      next_conflict_stat = !next_conflict_stat;
    end
    if (sv || rv) begin
      checkOutput("stat_grant", 64'(sa), 64'(exp_sa));
      checkOutput("rd_grant", 64'(ra), 64'(exp_ra));
    end
    if (sa) begin
      model_cnt[sid] = su ? TB_CNT_W'(sdat) : modelAdd(model_cnt[sid], sdat);
    end
    if (ra) begin
      e.due  = cyc + 2;
      e.id   = rid;
      e.data = model_cnt[rid];
      exp_q.push_back(e);
      if (rc) model_cnt[rid] = '0;
    end
    last_stat_acc = sa;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    checkResp();
  endtask

  task automatic statBeat(input logic [TB_ID_W-1:0] id, input logic [TB_INC_W-1:0] d, input bit load);
    applyStimulus(1'b1, id, d, load, 1'b0, '0, 1'b0);
  endtask

  task automatic readReq(input logic [TB_ID_W-1:0] id, input bit clr);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, id, clr);
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    end
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic readAll();
    for (int i = 0; i < N; i++) begin
      readReq(TB_ID_W'(i), 1'b0);
    end
    drain();
  endtask

  // Assert reset, check reset outputs, then time the init sweep.
  task automatic doReset();
    int cnt;
    bit done, bad_ready, resp_seen;
    rst_n = 1'b0;
    s_axis_stat_tvalid = 1'b0;
    rd_req_valid = 1'b0;
    #1;
    checkOutput("rst_tready", 64'(s_axis_stat_tready), 64'd0);
    checkOutput("rst_rd_req_ready", 64'(rd_req_ready), 64'd0);
    checkOutput("rst_resp_valid", 64'(rd_resp_valid), 64'd0);
    checkOutput("rst_resp_data", 64'(rd_resp_data), 64'd0);
    checkOutput("rst_init_done", 64'(init_done), 64'd0);
    exp_q.delete();
    for (int i = 0; i < N; i++) model_cnt[i] = '0;
    next_conflict_stat = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s_axis_stat_tvalid = 1'b1;
    rd_req_valid = 1'b1;
    cnt = 0;
    done = 1'b0;
    resp_seen = 1'b0;
    #1;
    bad_ready = s_axis_stat_tready | rd_req_ready;
    while (!done && cnt < 400) begin
      @(posedge clk);
      cnt++;
      cyc++;
      @(negedge clk);
      if (rd_resp_valid) resp_seen = 1'b1;
      if (init_done) begin
        done = 1'b1;
        s_axis_stat_tvalid = 1'b0;
        rd_req_valid = 1'b0;
      end else if (s_axis_stat_tready || rd_req_ready) begin
        bad_ready = 1'b1;
      end
    end
    s_axis_stat_tvalid = 1'b0;
    rd_req_valid = 1'b0;
    checkOutput("init_cycles", 64'(cnt), 64'(N));
    checkOutput("ready_during_init", 64'(bad_ready), 64'd0);
    checkOutput("resp_after_reset", 64'(resp_seen), 64'd0);
  endtask

  initial begin
    bit prev_stat;
    #2;
    $display("[TB] reset and init sweep");
    doReset();
    readAll();

    $display("[TB] back-to-back same-ID adds");
    statBeat(8'd5, 16'd3, 1'b0);
    statBeat(8'd5, 16'd7, 1'b0);
    readReq(8'd5, 1'b0);
    drain();

    $display("[TB] clear-on-read");
    repeat (4) statBeat(8'd9, 16'hFFFF, 1'b0);
    readReq(8'd9, 1'b1);
    readReq(8'd9, 1'b0);
    drain();

    $display("[TB] counter boundary");
    statBeat(8'd2, 16'hFFFF, 1'b1);
    repeat (15) statBeat(8'd2, 16'hFFFF, 1'b0);
    statBeat(8'd2, 16'h000E, 1'b0);
    readReq(8'd2, 1'b0);
    statBeat(8'd2, 16'd5, 1'b0);
    readReq(8'd2, 1'b0);
    statBeat(8'd2, 16'h0010, 1'b0);
    readReq(8'd2, 1'b0);
    drain();

    $display("[TB] read-clear followed by same-ID add");
    statBeat(8'd7, 16'd100, 1'b0);
    readReq(8'd7, 1'b1);
    statBeat(8'd7, 16'd4, 1'b0);
    readReq(8'd7, 1'b0);
    drain();

    $display("[TB] simultaneous requesters");
    prev_stat = 1'b0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 8'(10 + k % 3), 16'($urandom), 1'b0, 1'b1, 8'(10 + (k + 1) % 3), 1'b0);
      if (k > 0) checkOutput("alternate", 64'(last_stat_acc), 64'(!prev_stat));
      prev_stat = last_stat_acc;
    end
    drain();

    $display("[TB] randomized traffic");
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), 16'($urandom),
                    ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end
    drain();

    $display("[TB] reset with ops in flight");
    statBeat(8'd3, 16'd1, 1'b0);
    readReq(8'd3, 1'b0);
    doReset();
    readAll();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
